multicycle_ctrl: RTL and testbench

- Main control FSM that sequences the processor datapath over several cycles per instruction: fetch, decode, execute, memory, writeback.
- One shared memory port and one ALU are reused across the steps of each instruction.
- Adds a handshaked multi-cycle FPU execute phase with a watchdog, plus the second-register write enable used by long multiply.
- Sits beside the instruction decoder. Takes Op/Funct from the instruction register and drives the datapath mux selects and write enables.

---
 rtl/multicycle_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle processor control FSM: fetch/decode/execute/memory/writeback
// sequencing with a handshaked FPU execute phase and an FPU wait watchdog.
//
// state | meaning
// ------+------------------------------------------------------------
// 0     | FETCH  - load IR from memory[PC], PC <= PC + 4
// 1     | DECODE - read register file, ALU computes PC + 8
// 2     | MEMADR - ALU computes load/store address
// 3     | MEMRD  - read data memory at the address
// 4     | MEMWB  - write loaded data to the register file
// 5     | MEMWR  - write data memory
// 6     | EXECR  - ALU operation, register operand
// 7     | EXECI  - ALU operation, immediate operand
// 8     | ALUWB  - write ALU result (and product high half for long multiply)
// 9     | BRANCH - branch target computation, conditional PC write
// 10    | FPUEX  - wait for fpu_done, bounded by FPU_MAX_CYCLES
// 11    | FPUWB  - write FPU result
// 12-15 | illegal, recover to FETCH
module multicycle_ctrl #(
    parameter int FPU_MAX_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       IsMul,
    input  logic       fpu_done,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MulW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       ResSrc,
    output logic       fpu_start,
    output logic       fpu_err,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_FPUEX  = 4'd10;
    localparam logic [3:0] S_FPUWB  = 4'd11;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FPU_MAX_CYCLES);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             fpu_timeout;

    // Only Funct[5] (immediate) and Funct[0] (load) steer this block.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    // Done has priority: a timeout is only declared when fpu_done is low.
    assign fpu_timeout = (state_q == S_FPUEX) && (cnt_q == CNT_MAX) && !fpu_done;

    // State, FPU wait counter and sticky error flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state, counter and error-flag logic.
    always_comb begin
        state_d = S_FETCH;
        err_d   = err_q | fpu_timeout;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FPUEX;
                endcase
            end
            S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_d = S_ALUWB;
            S_FPUEX: begin
                if (fpu_done)         state_d = S_FPUWB;
                else if (fpu_timeout) state_d = S_FETCH;
                else                  state_d = S_FPUEX;
            end
            default:  state_d = S_FETCH;
        endcase

        // Counter holds the 1-based index of the current FPUEX cycle.
        if (state_d == S_FPUEX)
            cnt_d = (state_q == S_FPUEX) ? cnt_q + CNT_ONE : CNT_ONE;
        else
            cnt_d = '0;
    end

    // Moore output decode; write strobes and pulses are masked while reset is low.
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MulW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        ResSrc    = 1'b0;
        fpu_start = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_EXECR:  ALUOp = 1'b1;
            S_EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            S_ALUWB: begin
                RegW = 1'b1;
                MulW = IsMul;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            S_FPUEX: begin
                ALUSrcB   = Funct[5] ? 2'b01 : 2'b00;
                ResSrc    = 1'b1;
                fpu_start = (cnt_q == CNT_ONE);
            end
            S_FPUWB: begin
                ResSrc = 1'b1;
                RegW   = 1'b1;
            end
            default: ;
        endcase
        if (!reset) begin
            IRWrite   = 1'b0;
            NextPC    = 1'b0;
            RegW      = 1'b0;
            MulW      = 1'b0;
            MemW      = 1'b0;
            Branch    = 1'b0;
            fpu_start = 1'b0;
        end
    end

    assign fpu_err = err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed instruction classes, FPU boundary
// cases and random instruction streams against a per-instruction trace model.
module tb_multicycle_ctrl;

    localparam int FMAX = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IsMul;
    logic       fpu_done;
    logic       IRWrite, AdrSrc, NextPC, RegW, MulW, MemW, Branch, ALUOp, ResSrc;
    logic       fpu_start, fpu_err;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;
    bit model_err = 1'b0;

    multicycle_ctrl #(.FPU_MAX_CYCLES(FMAX), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .IsMul(IsMul),
        .fpu_done(fpu_done), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .NextPC(NextPC), .RegW(RegW), .MulW(MulW), .MemW(MemW),
        .Branch(Branch), .ALUOp(ALUOp), .ResSrc(ResSrc),
        .fpu_start(fpu_start), .fpu_err(fpu_err), .state(state)
    );

    always #5 clk = ~clk;

    // Output bundle order: IRWrite AdrSrc ALUSrcA ALUSrcB ResultSrc NextPC RegW MulW MemW Branch ALUOp ResSrc fpu_start
    function automatic logic [15:0] pk(input logic ir, input logic adr, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] rs, input logic np,
                                       input logic rw, input logic mw, input logic memw,
                                       input logic br, input logic aop, input logic rsrc,
                                       input logic st);
        return {ir, adr, a, b, rs, np, rw, mw, memw, br, aop, rsrc, st};
    endfunction

    function automatic logic [15:0] observed();
        return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MulW,
                MemW, Branch, ALUOp, ResSrc, fpu_start};
    endfunction

    // Expected outputs of one step, from the per-step output list.
    function automatic logic [15:0] exp_out(input int st, input logic imm, input logic mul,
                                            input logic first);
        case (st)
            0:  return pk(1, 0, 2'b10, 2'b10, 2'b10, 1, 0, 0,   0, 0, 0, 0, 0);
            1:  return pk(0, 0, 2'b10, 2'b10, 2'b10, 0, 0, 0,   0, 0, 0, 0, 0);
            2:  return pk(0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0,   0, 0, 0, 0, 0);
            3:  return pk(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0,   0, 0, 0, 0, 0);
            4:  return pk(0, 0, 2'b00, 2'b00, 2'b01, 0, 1, 0,   0, 0, 0, 0, 0);
            5:  return pk(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0,   1, 0, 0, 0, 0);
            6:  return pk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0,   0, 0, 1, 0, 0);
            7:  return pk(0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0,   0, 0, 1, 0, 0);
            8:  return pk(0, 0, 2'b00, 2'b00, 2'b00, 0, 1, mul, 0, 0, 0, 0, 0);
            9:  return pk(0, 0, 2'b00, 2'b01, 2'b10, 0, 0, 0,   0, 1, 0, 0, 0);
            10: return pk(0, 0, 2'b00, imm ? 2'b01 : 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, first);
            11: return pk(0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0,   0, 0, 0, 1, 0);
            default: return 16'hxxxx;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Run one instruction starting at a negedge in FETCH. done_at is the
    // FPUEX cycle (1-based) in which fpu_done rises; outside 1..FMAX it never does.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic mul,
                             input int done_at);
        int  seq[$];
        int  nfp;
        int  fidx;
        bit  tmo;
        seq = {0, 1};
        tmo = 1'b0;
        case (op)
            2'b00: begin seq.push_back(fn[5] ? 7 : 6); seq.push_back(8); end
            2'b01: begin
                seq.push_back(2);
                if (fn[0]) begin seq.push_back(3); seq.push_back(4); end
                else seq.push_back(5);
            end
            2'b10: seq.push_back(9);
            default: begin
                tmo = !(done_at >= 1 && done_at <= FMAX);
                nfp = tmo ? FMAX : done_at;
                repeat (nfp) seq.push_back(10);
                if (!tmo) seq.push_back(11);
            end
        endcase
        Op    = op;
        Funct = fn;
        IsMul = mul;
        fidx  = 0;
        foreach (seq[i]) begin
            if (seq[i] == 10) begin
                fidx++;
                fpu_done = (fidx == done_at);
            end else begin
                fpu_done = 1'($urandom_range(0, 1));
            end
            #1;
            check("state", {12'd0, state}, 16'(seq[i]));
            check("outputs", observed(), exp_out(seq[i], fn[5], mul, fidx == 1 && seq[i] == 10));
            check("fpu_err", {15'd0, fpu_err}, {15'd0, model_err});
            @(negedge clk);
        end
        if (tmo) model_err = 1'b1;
        fpu_done = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        Op       = 2'b00;
        Funct    = 6'd0;
        IsMul    = 1'b0;
        fpu_done = 1'b0;

        // Reset held low for three cycles: FETCH, write strobes masked.
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_state", {12'd0, state}, 16'd0);
            check("rst_outputs", observed(), pk(0, 0, 2'b10, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
            check("rst_err", {15'd0, fpu_err}, 16'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Directed classes.
        run_instr(2'b00, 6'b000000, 1'b0, 0);   // register ADD
        run_instr(2'b00, 6'b000000, 1'b1, 0);   // long multiply
        run_instr(2'b00, 6'b100000, 1'b0, 0);   // immediate
        run_instr(2'b01, 6'b000001, 1'b0, 0);   // LDR
        run_instr(2'b01, 6'b000000, 1'b0, 0);   // STR
        run_instr(2'b10, 6'b100000, 1'b0, 0);   // branch
        run_instr(2'b11, 6'b000000, 1'b0, 3);   // FPU, done in 3rd cycle
        run_instr(2'b11, 6'b100000, 1'b0, 1);   // FPU, done with start
        run_instr(2'b11, 6'b000000, 1'b0, FMAX); // done on timeout cycle wins
        run_instr(2'b11, 6'b000000, 1'b0, 0);   // timeout
        run_instr(2'b00, 6'b000000, 1'b0, 0);   // error stays set

        // Random instruction stream.
        for (int n = 0; n < 40; n++) begin
            run_instr(2'($urandom_range(0, 3)), 6'($urandom), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, FMAX + 3)));
        end

        // Reset during the MEMWB write cycle of a load.
        Op    = 2'b01;
        Funct = 6'b000001;
        repeat (4) @(negedge clk);
        #1;
        check("pre_abort_state", {12'd0, state}, 16'd4);
        #1;
        reset = 1'b0;
        #1;
        check("abort_state", {12'd0, state}, 16'd0);
        check("abort_regw", {15'd0, RegW}, 16'd0);
        check("abort_err", {15'd0, fpu_err}, 16'd0);
        model_err = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_instr(2'b00, 6'b000000, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout sim did not finish t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
